// File: rtl/top_conv_classifier_if.sv
// Memory-side bus of the conv classifier: KMEM plus the shared W1/W2 weight-bank ports.
// master = inference engine (drives addresses/enables), slave = SRAM side (drives read data).
interface top_conv_classifier_if #(
  parameter int NUM_ADDR = 5
);
  logic [NUM_ADDR-1:0] KMEM_ADD1, KMEM_ADD2;
  logic [NUM_ADDR-1:0] WMEM_ADD1, WMEM_ADD2;
  logic                KMEM_WEB1, KMEM_WEB2, KMEM_OEB1, KMEM_OEB2, KMEM_CSB1, KMEM_CSB2;
  logic                WMEM_WEB1, WMEM_WEB2, WMEM_OEB1, WMEM_OEB2, WMEM_CSB1, WMEM_CSB2;
  logic [31:0]         KR_DATA_I1, KR_DATA_I2;
  logic [31:0]         W1_DATA_I1, W1_DATA_I2;
  logic [31:0]         W2_DATA_I1, W2_DATA_I2;

  modport master (
    output KMEM_ADD1, KMEM_ADD2, WMEM_ADD1, WMEM_ADD2,
    output KMEM_WEB1, KMEM_WEB2, KMEM_OEB1, KMEM_OEB2, KMEM_CSB1, KMEM_CSB2,
    output WMEM_WEB1, WMEM_WEB2, WMEM_OEB1, WMEM_OEB2, WMEM_CSB1, WMEM_CSB2,
    input  KR_DATA_I1, KR_DATA_I2, W1_DATA_I1, W1_DATA_I2, W2_DATA_I1, W2_DATA_I2
  );

  modport slave (
    input  KMEM_ADD1, KMEM_ADD2, WMEM_ADD1, WMEM_ADD2,
    input  KMEM_WEB1, KMEM_WEB2, KMEM_OEB1, KMEM_OEB2, KMEM_CSB1, KMEM_CSB2,
    input  WMEM_WEB1, WMEM_WEB2, WMEM_OEB1, WMEM_OEB2, WMEM_CSB1, WMEM_CSB2,
    output KR_DATA_I1, KR_DATA_I2, W1_DATA_I1, W1_DATA_I2, W2_DATA_I1, W2_DATA_I2
  );
endinterface

// File: rtl/top_conv_classifier.sv
// 2x2 conv over a 3x3 image followed by a 4-neuron scorer with argmax; kernel/weights loaded from SRAM.
// Define CONV_RELU_EN to clamp conv outputs to 0..255; otherwise the low byte wraps.
module top_conv_classifier #(
  parameter int NUM_ADDR = 5,
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         learn,
  input  logic                         classify,
  input  logic [2:0][DATA_W-1:0]       InputImage [2:0],
  top_conv_classifier_if.master        mem,
  output logic [3:0][DATA_W-1:0]       pixels,
  output logic [7:0]                   result
);

  localparam int ACC_W   = 18;
  localparam int SCORE_W = 19;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD0  = 3'd1,
    LD1  = 3'd2,
    LD2  = 3'd3,
    CONV = 3'd4,
    FC   = 3'd5
  } state_t;

  state_t state, state_nx;
  logic   loaded;

  logic                 rd_en_n_q;
  logic [NUM_ADDR-1:0]  rd_addr_q;

  logic signed [COEF_W-1:0]  kern_q  [4];
  logic signed [COEF_W-1:0]  wgt_q   [4][4];
  logic signed [COEF_W-1:0]  bias_q  [4];
  logic        [2:0]         shift_q;

  logic [DATA_W-1:0]         pix_d   [4];
  logic [3:0][DATA_W-1:0]    pix_p0;
  logic signed [SCORE_W-1:0] score_p1 [4];
  logic [1:0]                best_p1;
  logic [1:0]                res_p1;

  logic unused_kr2;
  assign unused_kr2 = ^mem.KR_DATA_I2;

  // Signed kernel tap times unsigned pixel, widened to the accumulator width.
  function automatic logic signed [ACC_W-1:0] conv_term(input logic signed [COEF_W-1:0] k,
                                                          input logic [DATA_W-1:0] p);
    conv_term = ACC_W'(k) * ACC_W'($signed({1'b0, p}));
  endfunction

  function automatic logic [DATA_W-1:0] sat_pixel(input logic signed [ACC_W-1:0] a);
`ifdef CONV_RELU_EN
    if (a < 0)
      sat_pixel = '0;
    else if (a > ACC_W'((1 << DATA_W) - 1))
      sat_pixel = '1;
    else
      sat_pixel = a[DATA_W-1:0];
`else
    sat_pixel = DATA_W'(a);
`endif
  endfunction

  function automatic logic signed [SCORE_W-1:0] fc_term(input logic signed [COEF_W-1:0] w,
                                                         input logic [DATA_W-1:0] p);
    fc_term = SCORE_W'(w) * SCORE_W'($signed({1'b0, p}));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // learn overrides every state, including an in-flight classification.
  always_comb begin
    state_nx = state;
    if (learn) begin
      state_nx = LD0;
    end else begin
      case (state)
        IDLE:    if (classify && loaded) state_nx = CONV;
        LD0:     state_nx = LD1;
        LD1:     state_nx = LD2;
        LD2:     state_nx = IDLE;
        CONV:    state_nx = FC;
        FC:      state_nx = (classify && loaded) ? CONV : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded <= 1'b0;
    end else if (learn) begin
      loaded <= 1'b0;
    end else if (state == LD2) begin
      loaded <= 1'b1;
    end
  end

  // SRAM controls are registered off the next state so they change cleanly with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_n_q <= 1'b1;
      rd_addr_q <= '0;
    end else begin
      rd_en_n_q <= !((state_nx == LD0) || (state_nx == LD1));
      rd_addr_q <= ((state_nx == LD1) || (state_nx == LD2)) ? NUM_ADDR'(1) : '0;
    end
  end

  assign mem.KMEM_ADD1 = rd_addr_q;
  assign mem.KMEM_ADD2 = '0;
  assign mem.WMEM_ADD1 = rd_addr_q;
  assign mem.WMEM_ADD2 = rd_addr_q;
  assign mem.KMEM_WEB1 = 1'b1;
  assign mem.KMEM_WEB2 = 1'b1;
  assign mem.WMEM_WEB1 = 1'b1;
  assign mem.WMEM_WEB2 = 1'b1;
  assign mem.KMEM_CSB1 = rd_en_n_q;
  assign mem.KMEM_OEB1 = rd_en_n_q;
  assign mem.KMEM_CSB2 = 1'b1;
  assign mem.KMEM_OEB2 = 1'b1;
  assign mem.WMEM_CSB1 = rd_en_n_q;
  assign mem.WMEM_OEB1 = rd_en_n_q;
  assign mem.WMEM_CSB2 = rd_en_n_q;
  assign mem.WMEM_OEB2 = rd_en_n_q;

  // Word 0 arrives during LD1 (kernel, weights), word 1 during LD2 (shift, biases).
  always_ff @(posedge clk) begin
    if (state == LD1) begin
      for (int k = 0; k < 4; k++) begin
        kern_q[k]    <= mem.KR_DATA_I1[COEF_W*k +: COEF_W];
        wgt_q[0][k]  <= mem.W1_DATA_I1[COEF_W*k +: COEF_W];
        wgt_q[1][k]  <= mem.W1_DATA_I2[COEF_W*k +: COEF_W];
        wgt_q[2][k]  <= mem.W2_DATA_I1[COEF_W*k +: COEF_W];
        wgt_q[3][k]  <= mem.W2_DATA_I2[COEF_W*k +: COEF_W];
      end
    end
    if (state == LD2) begin
      shift_q   <= mem.KR_DATA_I1[2:0];
      bias_q[0] <= mem.W1_DATA_I1[COEF_W-1:0];
      bias_q[1] <= mem.W1_DATA_I2[COEF_W-1:0];
      bias_q[2] <= mem.W2_DATA_I1[COEF_W-1:0];
      bias_q[3] <= mem.W2_DATA_I2[COEF_W-1:0];
    end
  end

  // ---- stage p0: convolution, captured at the end of CONV ----
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    for (int n = 0; n < 4; n++) pix_d[n] = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        acc = '0;
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 2; j++) begin
            acc = acc + conv_term(kern_q[i*2+j], InputImage[r+i][c+j]);
          end
        end
        acc_sh = acc >>> shift_q;
        pix_d[r*2+c] = sat_pixel(acc_sh);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_p0 <= '0;
    end else if ((state == CONV) && !learn) begin
      for (int n = 0; n < 4; n++) pix_p0[n] <= pix_d[n];
    end
  end

  assign pixels = pix_p0;

  // ---- stage p1: neuron scores and argmax, captured at the end of FC ----
  always_comb begin
    logic signed [SCORE_W-1:0] best_sc;
    for (int n = 0; n < 4; n++) begin
      score_p1[n] = SCORE_W'(bias_q[n]);
      for (int k = 0; k < 4; k++) begin
        score_p1[n] = score_p1[n] + fc_term(wgt_q[n][k], pix_p0[k]);
      end
    end
    best_p1 = 2'd0;
    best_sc = score_p1[0];
    // Strict compare keeps the lowest index on ties.
    for (int n = 1; n < 4; n++) begin
      if (score_p1[n] > best_sc) begin
        best_p1 = 2'(n);
        best_sc = score_p1[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1 <= 2'd0;
    end else if ((state == FC) && !learn) begin
      res_p1 <= best_p1;
    end
  end

  assign result = {6'd0, res_p1};

endmodule

// File: tb/tb_top_conv_classifier.sv
// Directed bench for top_conv_classifier with a 1-cycle-latency SRAM model on the memory bus.
module tb_top_conv_classifier;

  logic clk = 1'b0;
  logic rst, learn, classify;
  logic [2:0][7:0] img [2:0];
  logic [3:0][7:0] pixels;
  logic [7:0]      result;

  int n_chk  = 0;
  int n_fail = 0;
  logic bad;

  top_conv_classifier_if #(.NUM_ADDR(5)) mif ();

  top_conv_classifier dut (
    .clk        (clk),
    .rst        (rst),
    .learn      (learn),
    .classify   (classify),
    .InputImage (img),
    .mem        (mif),
    .pixels     (pixels),
    .result     (result)
  );

  always #5 clk = ~clk;

  logic [31:0] kmem [32];
  logic [31:0] w1a [32], w1b [32], w2a [32], w2b [32];
  logic [4:0]  ka_q = '0, wa_q = '0, wb_q = '0;

  always @(posedge clk) begin
    if (!mif.KMEM_CSB1) ka_q <= mif.KMEM_ADD1;
    if (!mif.WMEM_CSB1) wa_q <= mif.WMEM_ADD1;
    if (!mif.WMEM_CSB2) wb_q <= mif.WMEM_ADD2;
  end

  assign mif.KR_DATA_I1 = kmem[ka_q];
  assign mif.KR_DATA_I2 = 32'h0;
  assign mif.W1_DATA_I1 = w1a[wa_q];
  assign mif.W1_DATA_I2 = w1b[wb_q];
  assign mif.W2_DATA_I1 = w2a[wa_q];
  assign mif.W2_DATA_I2 = w2b[wb_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic [31:0] k0, k1,
                         input logic [31:0] a0, b0, c0, d0,
                         input logic [31:0] a1, b1, c1, d1);
    kmem[0] = k0; kmem[1] = k1;
    w1a[0] = a0; w1b[0] = b0; w2a[0] = c0; w2b[0] = d0;
    w1a[1] = a1; w1b[1] = b1; w2a[1] = c1; w2b[1] = d1;
  endtask

  task automatic set_img_all(input logic [7:0] v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        img[r][c] = v;
  endtask

  task automatic do_learn(input string tag);
    learn = 1'b1;
    tick();
    chk({tag, "_ld0_kadd"}, 32'(mif.KMEM_ADD1), 32'd0);
    chk({tag, "_ld0_kcsb"}, 32'(mif.KMEM_CSB1), 32'd0);
    tick();
    learn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic run_classify();
    classify = 1'b1;
    tick();
    classify = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      kmem[i] = '0; w1a[i] = '0; w1b[i] = '0; w2a[i] = '0; w2b[i] = '0;
    end
    rst = 1'b1; learn = 1'b0; classify = 1'b0;
    set_img_all(8'd10);

    // Reset state
    tick();
    rst = 1'b0;
    chk("rst_kcsb1", 32'(mif.KMEM_CSB1), 32'd1);
    chk("rst_koeb1", 32'(mif.KMEM_OEB1), 32'd1);
    chk("rst_kweb1", 32'(mif.KMEM_WEB1), 32'd1);
    chk("rst_wcsb1", 32'(mif.WMEM_CSB1), 32'd1);
    chk("rst_wcsb2", 32'(mif.WMEM_CSB2), 32'd1);
    chk("rst_kadd1", 32'(mif.KMEM_ADD1), 32'd0);
    chk("rst_wadd2", 32'(mif.WMEM_ADD2), 32'd0);
    chk("rst_pixels", pixels, 32'd0);
    chk("rst_result", 32'(result), 32'd0);

    // classify before any learn is ignored
    bad = 1'b0;
    classify = 1'b1;
    repeat (6) begin
      tick();
      bad = bad | ~mif.KMEM_CSB1 | ~mif.KMEM_OEB1 | ~mif.WMEM_CSB1 | ~mif.WMEM_CSB2;
    end
    classify = 1'b0;
    chk("nolearn_mem_enabled", 32'(bad), 32'd0);
    chk("nolearn_result", 32'(result), 32'd0);

    // Zero kernel, shift 1: scores are the biases 18,19,34,35
    set_mem(32'h0, 32'h1, 32'h10, 32'h11, 32'h20, 32'h21, 32'h12, 32'h13, 32'h22, 32'h23);
    do_learn("t1");
    run_classify();
    chk("t1_pixels", pixels, 32'h0);
    chk("t1_result", 32'(result), 32'd3);

    // Unit kernel, image 10 -> 40 everywhere, only n0 weighted
    set_mem(32'h01010101, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    do_learn("t2");
    run_classify();
    chk("t2_pixels", pixels, 32'h28282828);
    chk("t2_result", 32'(result), 32'd0);

    // Kernel -1, image 100 -> acc -400; tie between n1/n2 biases (upper bits of words ignored)
    set_mem(32'hFFFFFFFF, 32'hFFFFFFF8, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h00000001, 32'hABCDEF05, 32'h00000005, 32'h00000002);
    set_img_all(8'd100);
    do_learn("t3");
    run_classify();
`ifdef CONV_RELU_EN
    chk("t3_pixels", pixels, 32'h00000000);
`else
    chk("t3_pixels", pixels, 32'h70707070);
`endif
    chk("t3_tie_result", 32'(result), 32'd1);

    // Kernel 127, image 255, shift 2 -> acc 32385
    set_mem(32'h7F7F7F7F, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3);
    set_img_all(8'd255);
    do_learn("t4");
    run_classify();
`ifdef CONV_RELU_EN
    chk("t4_pixels", pixels, 32'hFFFFFFFF);
`else
    chk("t4_pixels", pixels, 32'h81818181);
`endif
    chk("t4_result", 32'(result), 32'd3);

    // Distinct taps and pixels -> p00=37 p01=47 p10=67 p11=77; scores 37,10,47,-77
    set_mem(32'h04030201, 32'h0, 32'h00000001, 32'h0, 32'h00000100, 32'hFF000000,
            32'h0, 32'h0000000A, 32'h0, 32'h0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        img[r][c] = 8'(r*3 + c + 1);
    do_learn("t5");
    run_classify();
    chk("t5_pixels", pixels, 32'h4D432F25);
    chk("t5_result", 32'(result), 32'd2);

    // Back-to-back: classify held through FC starts the next CONV immediately
    classify = 1'b1;
    tick();
    tick();
    tick();
    chk("b2b_first_result", 32'(result), 32'd2);
    set_img_all(8'd0);
    img[0][0] = 8'd100;
    classify = 1'b0;
    tick();
    chk("b2b_second_pixels", pixels, 32'h00000064);
    tick();
    chk("b2b_second_result", 32'(result), 32'd0);

    // learn during FC aborts the classification
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        img[r][c] = 8'(r*3 + c + 1);
    classify = 1'b1;
    tick();
    classify = 1'b0;
    tick();
    learn = 1'b1;
    tick();
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_wadd1", 32'(mif.WMEM_ADD1), 32'd0);
    chk("abort_kcsb1", 32'(mif.KMEM_CSB1), 32'd0);
    learn = 1'b0;
    repeat (4) tick();
    run_classify();
    chk("reload_result", 32'(result), 32'd2);

    // Reset mid-classification, then classify without reloading is ignored
    classify = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pixels", pixels, 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_wcsb1", 32'(mif.WMEM_CSB1), 32'd1);
    repeat (5) tick();
    classify = 1'b0;
    chk("postrst_result", 32'(result), 32'd0);
    chk("postrst_pixels", pixels, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
